// File: rtl/rx_lane_buffer_pkg.sv
// Shared definitions for the serial receive lane buffer: lane FSM encoding,
// default comma symbol and a ceil-log2 helper for sizing counters and pointers.
package rx_lane_buffer_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } lane_state_t;

  localparam logic [7:0] DEFAULT_COMMA = 8'hBC;

  // Returns ceil(log2(v)), never less than 1 so every counter has a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rx_lane_buffer_lane.sv
// One receive lane: MSB-first deserialiser, comma-alignment FSM and a
// DEPTH-entry FIFO of data words popped through rd/dout.
module rx_lane
  import rx_lane_buffer_pkg::*;
#(
  parameter int              DW       = 8,
  parameter int              DEPTH    = 4,
  parameter int              AF_TH    = DEPTH - 1,
  parameter int              AE_TH    = 1,
  parameter logic [DW-1:0]   COMMA    = DW'(DEFAULT_COMMA),
  parameter int              SYNC_CNT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          active,
  output logic          error,
  output logic [1:0]    state
);

  localparam int BW = clog2(DW);
  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam int SW = clog2(SYNC_CNT + 1);

  lane_state_t   cur;
  logic [DW-1:0] sr;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] comma_cnt;
  logic [DW-1:0] wr_data;
  logic          wr_pend;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic [DW-1:0] word;
  logic          boundary;
  logic          pop;
  logic          push_ok;

  assign word     = {sr[DW-2:0], din};
  assign boundary = (bit_cnt == BW'(DW - 1));

  // Pop handshake: rd is a request, honoured only when the FIFO holds a word;
  // dout/dout_valid follow one edge later. A push into a full FIFO is only
  // accepted when a pop frees the slot on the same edge.
  assign pop     = rd && (count != '0);
  assign push_ok = wr_pend && (!full || pop);

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (int'(count) >= AF_TH);
  assign almost_empty = (int'(count) <= AE_TH);
  assign active       = (cur == ACTIVE);
  assign state        = cur;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur        <= SEARCH;
      sr         <= '0;
      bit_cnt    <= '0;
      comma_cnt  <= '0;
      wr_data    <= '0;
      wr_pend    <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      sr      <= word;
      wr_pend <= 1'b0;
      case (cur)
        SEARCH: begin
          if (word == COMMA) begin
            bit_cnt   <= '0;
            comma_cnt <= SW'(1);
            cur       <= ALIGN;
          end
        end
        ALIGN: begin
          bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
          if (boundary) begin
            if (word == COMMA) begin
              comma_cnt <= comma_cnt + 1'b1;
              if (comma_cnt + 1'b1 == SW'(SYNC_CNT)) cur <= ACTIVE;
            end else begin
              comma_cnt <= '0;
              cur       <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
          // Commas in the data stream are idle fill and never reach the FIFO.
          if (boundary && word != COMMA) begin
            wr_data <= word;
            wr_pend <= 1'b1;
          end
        end
        default: cur <= SEARCH;
      endcase

      dout_valid <= pop;
      if (pop) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      if (push_ok) wptr <= wptr + 1'b1;
      if (push_ok && !pop) count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if ((wr_pend && full && !pop) || (rd && empty)) error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/rx_lane_buffer.sv
// NCH independent serial receive lanes, each with comma alignment and its own
// pop-side FIFO; lane k uses bit k of every per-lane vector.
module rx_lane_buffer
  import rx_lane_buffer_pkg::*;
#(
  parameter int            NCH      = 2,
  parameter int            DW       = 8,
  parameter int            DEPTH    = 4,
  parameter int            AF_TH    = DEPTH - 1,
  parameter int            AE_TH    = 1,
  parameter logic [DW-1:0] COMMA    = DW'(DEFAULT_COMMA),
  parameter int            SYNC_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    in,
  input  logic [NCH-1:0]    read,
  output logic [NCH*DW-1:0] out,
  output logic [NCH-1:0]    out_valid,
  output logic [NCH-1:0]    empty,
  output logic [NCH-1:0]    full,
  output logic [NCH-1:0]    almost_full,
  output logic [NCH-1:0]    almost_empty,
  output logic [NCH-1:0]    active,
  output logic [NCH-1:0]    error,
  output logic [2*NCH-1:0]  lane_state
);

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    rx_lane #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AF_TH    (AF_TH),
      .AE_TH    (AE_TH),
      .COMMA    (COMMA),
      .SYNC_CNT (SYNC_CNT)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .din          (in[k]),
      .rd           (read[k]),
      .dout         (out[k*DW +: DW]),
      .dout_valid   (out_valid[k]),
      .empty        (empty[k]),
      .full         (full[k]),
      .almost_full  (almost_full[k]),
      .almost_empty (almost_empty[k]),
      .active       (active[k]),
      .error        (error[k]),
      .state        (lane_state[2*k +: 2])
    );
  end

endmodule

// File: tb/tb_rx_lane_buffer.sv
// Directed bench for rx_lane_buffer (NCH=2, DW=8, DEPTH=4): lane 0 carries the
// traffic, lane 1 idles on zeros and must stay untouched.
module tb_rx_lane_buffer;

  logic        clk;
  logic        reset;
  logic [1:0]  in;
  logic [1:0]  read;
  logic [15:0] out;
  logic [1:0]  out_valid;
  logic [1:0]  empty;
  logic [1:0]  full;
  logic [1:0]  almost_full;
  logic [1:0]  almost_empty;
  logic [1:0]  active;
  logic [1:0]  error;
  logic [3:0]  lane_state;

  rx_lane_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in),
    .read         (read),
    .out          (out),
    .out_valid    (out_valid),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .active       (active),
    .error        (error),
    .lane_state   (lane_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // flags order: {active, empty, full, almost_full, almost_empty, error}
  typedef struct {
    logic [7:0] b;
    logic       rd;
    logic       ov;
    logic [7:0] dout;
    logic [5:0] flags;
  } vec_t;

  vec_t tbl [20];

  logic [7:0] cap_out;
  logic [1:0] cap_ov;
  logic [5:0] cap_flags;
  logic [6:0] cap_l1;

  function automatic logic [5:0] flags0();
    return {active[0], empty[0], full[0], almost_full[0], almost_empty[0], error[0]};
  endfunction

  function automatic logic [6:0] lane1_bits();
    return {active[1], empty[1], full[1], almost_full[1], almost_empty[1], error[1], out_valid[1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one byte MSB-first on lane 0 (lane 1 sends zeros); read[0] is
  // pulsed on the first bit, and outputs are captured #1 after that edge.
  task automatic xfer(input logic [7:0] b0, input logic rd0);
    for (int j = 7; j >= 0; j--) begin
      in   = {1'b0, b0[j]};
      read = (j == 7) ? {1'b0, rd0} : 2'b00;
      @(posedge clk);
      #1;
      if (j == 7) begin
        cap_out   = out[7:0];
        cap_ov    = out_valid;
        cap_flags = flags0();
        cap_l1    = lane1_bits();
      end
    end
    in   = 2'b00;
    read = 2'b00;
  endtask

  task automatic do_reset(input int cycles);
    in    = 2'b00;
    read  = 2'b00;
    reset = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp_word);
    xfer(8'hBC, 1'b1);
    chk({name, "_valid"}, 32'(cap_ov), 32'b01);
    chk({name, "_word"}, 32'(cap_out), 32'(exp_word));
  endtask

  initial begin
    reset = 1'b0;
    in    = 2'b00;
    read  = 2'b00;

    // lock on 4 commas, two data words, two pops, then overflow and drain
    tbl[0]  = '{8'hBC, 1'b0, 1'b0, 8'h00, 6'b010010};
    tbl[1]  = '{8'hBC, 1'b0, 1'b0, 8'h00, 6'b010010};
    tbl[2]  = '{8'hBC, 1'b0, 1'b0, 8'h00, 6'b010010};
    tbl[3]  = '{8'hBC, 1'b0, 1'b0, 8'h00, 6'b010010};
    tbl[4]  = '{8'hA5, 1'b0, 1'b0, 8'h00, 6'b110010};
    tbl[5]  = '{8'h3C, 1'b0, 1'b0, 8'h00, 6'b100010};
    tbl[6]  = '{8'hBC, 1'b1, 1'b1, 8'hA5, 6'b100010};
    tbl[7]  = '{8'hBC, 1'b1, 1'b1, 8'h3C, 6'b110010};
    tbl[8]  = '{8'hBC, 1'b0, 1'b0, 8'h3C, 6'b110010};
    tbl[9]  = '{8'h11, 1'b0, 1'b0, 8'h3C, 6'b110010};
    tbl[10] = '{8'h22, 1'b0, 1'b0, 8'h3C, 6'b100010};
    tbl[11] = '{8'h33, 1'b0, 1'b0, 8'h3C, 6'b100000};
    tbl[12] = '{8'h44, 1'b0, 1'b0, 8'h3C, 6'b100100};
    tbl[13] = '{8'h55, 1'b0, 1'b0, 8'h3C, 6'b101100};
    tbl[14] = '{8'hBC, 1'b0, 1'b0, 8'h3C, 6'b101101};
    tbl[15] = '{8'hBC, 1'b1, 1'b1, 8'h11, 6'b100101};
    tbl[16] = '{8'hBC, 1'b1, 1'b1, 8'h22, 6'b100001};
    tbl[17] = '{8'hBC, 1'b1, 1'b1, 8'h33, 6'b100011};
    tbl[18] = '{8'hBC, 1'b1, 1'b1, 8'h44, 6'b110011};
    tbl[19] = '{8'hBC, 1'b1, 1'b0, 8'h44, 6'b110011};

    // reset state
    do_reset(2);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_empty", 32'(empty), 32'b11);
    chk("rst_ae", 32'(almost_empty), 32'b11);
    chk("rst_full_af", 32'({full, almost_full}), 32'h0);
    chk("rst_active", 32'(active), 32'b00);
    chk("rst_error", 32'(error), 32'b00);
    chk("rst_valid", 32'(out_valid), 32'b00);
    chk("rst_state", 32'(lane_state), 32'h0);

    for (int i = 0; i < 20; i++) begin
      xfer(tbl[i].b, tbl[i].rd);
      chk($sformatf("vec%0d_valid", i), 32'(cap_ov), 32'({1'b0, tbl[i].ov}));
      chk($sformatf("vec%0d_out", i), 32'(cap_out), 32'(tbl[i].dout));
      chk($sformatf("vec%0d_flags", i), 32'(cap_flags), 32'(tbl[i].flags));
      chk($sformatf("vec%0d_lane1", i), 32'(cap_l1), 32'b0100100);
    end

    // mid-operation reset with two words held
    xfer(8'h11, 1'b0);
    xfer(8'h22, 1'b0);
    xfer(8'hBC, 1'b0);
    chk("hold2_flags", 32'(flags0()), 32'b100001);
    do_reset(1);
    chk("midrst_flags", 32'(flags0()), 32'b010010);
    chk("midrst_out", 32'(out), 32'h0);
    xfer(8'hA5, 1'b0);
    xfer(8'hBC, 1'b0);
    chk("relock_needed", 32'({active[0], empty[0]}), 32'b01);
    chk("relock_align", 32'(lane_state[1:0]), 32'd1);
    for (int i = 0; i < 3; i++) xfer(8'hBC, 1'b0);
    chk("relock_active", 32'(active), 32'b01);

    // full boundary: push and pop on the same edge while full
    xfer(8'hA1, 1'b0);
    xfer(8'hA2, 1'b0);
    xfer(8'hA3, 1'b0);
    xfer(8'hA4, 1'b0);
    xfer(8'hB5, 1'b0);
    chk("fb_full", 32'(cap_flags), 32'b101100);
    xfer(8'hBC, 1'b1);
    chk("fb_pop_valid", 32'(cap_ov), 32'b01);
    chk("fb_pop_word", 32'(cap_out), 32'hA1);
    chk("fb_still_full", 32'(cap_flags), 32'b101100);
    pop_chk("fb_pop2", 8'hA2);
    pop_chk("fb_pop3", 8'hA3);
    pop_chk("fb_pop4", 8'hA4);
    pop_chk("fb_pop5", 8'hB5);
    chk("fb_drained", 32'(cap_flags), 32'b110010);

    // sync failure: three commas then a data word
    do_reset(2);
    for (int i = 0; i < 3; i++) xfer(8'hBC, 1'b0);
    chk("sf_align", 32'(lane_state[1:0]), 32'd1);
    xfer(8'h55, 1'b0);
    chk("sf_search", 32'(lane_state[1:0]), 32'd0);
    chk("sf_inactive", 32'(active), 32'b00);
    xfer(8'h00, 1'b0);
    chk("sf_empty", 32'(empty), 32'b11);

    // read while empty: no valid, error on that lane only
    xfer(8'h00, 1'b1);
    chk("re_valid", 32'(cap_ov), 32'b00);
    chk("re_out", 32'(cap_out), 32'h00);
    chk("re_error", 32'(error), 32'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
